alcom_sched: RTL and testbench
==============================

# alcom_sched

Round-robin scheduler that shares the single alcom decode unit between `NREQ` requesters. Each requester presents a 4-bit operation field, a 4-bit register-select field and an enable. The block grants one requester at a time and drives the decoder's op inputs (x07..x10), select inputs (x11..x14) and enable (x03) stably for a fixed hold window. When the window ends, it signals completion. It sits between the requesting control units and the combinational alcom decoder.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `HOLD_CYC`, 2: cycles the decoder inputs are held per transaction, 1..15. 0 is illegal.
- `BURST_MAX`, 4: maximum back-to-back grants to one requester. Used only with `ALCOM_SCHED_BURST_EN`. Range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_op`  in  4*NREQ  op field. Slice i is `[4i+3:4i]`. Bit 3→x07, bit 2→x08, bit 1→x09, bit 0→x10.
- `req_sel`  in  4*NREQ  select field. Bit 3→x11, bit 2→x12, bit 1→x13, bit 0→x14.
- `req_en`  in  NREQ  select enable, which maps to x03.
- `req_ready`  out  NREQ  one-hot accept. A transfer occurs when `req_valid[i] & req_ready[i]` at a rising edge.
- `dec_op`  out  4  registered drive to x07..x10.
- `dec_sel`  out  4  registered drive to x11..x14.
- `dec_en`  out  1  registered drive to x03.
- `dec_active`  out  1  decoder outputs are meaningful. Consumers must qualify all alcom outputs with it.
- `gnt_id`  out  $clog2(NREQ)  index of the requester currently being served.
- `done`  out  1  single-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DRIVE, DONE.
- **IDLE**
  - Round-robin search starting at `last+1` mod NREQ for the first set `req_valid` bit.
  - `req_ready[winner]` is asserted combinationally. All other ready bits are 0.
  - On the transfer edge: capture op/sel/en into `dec_*`, set `dec_active=1`, set `gnt_id=winner`, set `last=winner`, load the hold counter with `HOLD_CYC-1`, go to DRIVE.
  - If no request is valid, stay in IDLE.
- **DRIVE**
  - `dec_*` are held constant and `req_ready=0`.
  - The counter decrements each cycle. At 0 the FSM goes to DONE.
- **DONE**
  - `done=1` for this one cycle.
  - `dec_op`, `dec_sel`, `dec_en` and `dec_active` are all 0 from the edge that enters DONE.
  - Next state is IDLE (see Configuration for burst).
- Idle values: `dec_op=0`, `dec_sel=0`, `dec_en=0`, `dec_active=0`. An idle op of 0 still decodes to z06, which is why consumers must gate on `dec_active`.
- Requesters must hold `req_valid` and their fields stable until ready. Changes while not ready are ignored.
- If a requester deasserts `req_valid` in IDLE before the edge, no transfer occurs and arbitration re-evaluates on the next cycle.
- All requests valid: service order is 0,1,2,…,NREQ-1,0,… with no starvation.

## Timing
- Reset values: `state=IDLE`, `last=NREQ-1` (requester 0 has first priority), `dec_op=0`, `dec_sel=0`, `dec_en=0`, `dec_active=0`, `done=0`, `busy=0`, `gnt_id=0`, counter 0.
- Reset is asynchronous. Assertion mid-DRIVE clears all outputs immediately. No `done` is issued for the aborted transaction.
- Latency: accept at edge E0; `dec_*` valid in cycles E0+1 .. E0+HOLD_CYC; `done` high in cycle E0+HOLD_CYC+1.
- Throughput without burst: one transaction per `HOLD_CYC+2` cycles.
- `req_ready` is the only combinational output. It depends on `state`, `last` and `req_valid` only.

## Configuration
- Macro: `ALCOM_SCHED_BURST_EN`.
- **Defined:**
  - In DONE, if `req_valid[gnt_id]` is high and the burst count is below `BURST_MAX`, `req_ready[gnt_id]` asserts in DONE.
  - On transfer the FSM goes directly to DRIVE. `done` still pulses, and `dec_*` load the new values on the same edge.
  - Throughput becomes `HOLD_CYC+1` cycles per transaction.
  - The burst count resets to 1 on every IDLE grant. When it reaches `BURST_MAX`, the FSM returns to IDLE and round-robin arbitration resumes.
- **Undefined:** no burst logic or counter is present. DONE always returns to IDLE.

## Test plan
- Reset, then requester 2 only with op=4'b1001, sel=4'b0110, en=1 → `req_ready=4'b0100` in the first idle cycle; `dec_op=9`, `dec_sel=6`, `dec_en=1`, `dec_active=1` for 2 cycles; `done` on the 3rd cycle; `gnt_id=2`.
- All four requesters valid continuously → grant order 0,1,2,3,0,1. Consecutive `done` pulses are 4 cycles apart (HOLD_CYC=2).
- Assert `rst_n=0` in the second DRIVE cycle → `dec_*=0` and `dec_active=0` immediately; no `done`; after release, requester 0 wins first.
- `req_valid` pulsed for 1 cycle while another transaction is in DRIVE → no transfer for the pulsed requester, and it is never granted.
- With `ALCOM_SCHED_BURST_EN` and BURST_MAX=2, requesters 1 and 3 both valid → 1,1,3,3,1,1. Within a burst, transactions are spaced 3 cycles apart.

Source files
------------

// File: rtl/alcom_sched.sv
// alcom_sched: round-robin scheduler sharing one alcom decoder between NREQ requesters.
// Optional back-to-back burst grants are enabled with `define ALCOM_SCHED_BURST_EN.
module alcom_sched #(
  parameter int NREQ      = 4,
  parameter int HOLD_CYC  = 2,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [4*NREQ-1:0]       req_op,
  input  logic [4*NREQ-1:0]       req_sel,
  input  logic [NREQ-1:0]         req_en,
  output logic [NREQ-1:0]         req_ready,
  output logic [3:0]              dec_op,
  output logic [3:0]              dec_sel,
  output logic                    dec_en,
  output logic                    dec_active,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    done,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);

  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("alcom_sched: HOLD_CYC out of range 1..15");
  end
  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
    $error("alcom_sched: BURST_MAX out of range 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_last, r_gnt, w_winner, w_src, w_cand;
  logic [IW:0]     w_sum;
  logic            w_any, w_xfer;
  logic [NREQ-1:0] w_ready;
  logic [3:0]      r_cnt, r_op, r_sel, w_op, w_sel;
  logic            r_en, r_active, r_done, r_busy, w_en;
`ifdef ALCOM_SCHED_BURST_EN
  logic [3:0]      r_burst;
`endif

  // Descending scan so the last hit is the nearest requester after r_last.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sum = {1'b0, r_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      w_cand = w_sum[IW-1:0];
      if (req_valid[w_cand]) begin
        w_any    = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_any) w_ready[w_winner] = 1'b1;
`ifdef ALCOM_SCHED_BURST_EN
    if (r_state == S_DONE && req_valid[r_last] && r_burst < 4'(BURST_MAX))
      w_ready[r_last] = 1'b1;
`endif
  end

  assign req_ready = w_ready;
  assign w_xfer    = |(req_valid & w_ready);
  assign w_src     = (r_state == S_IDLE) ? w_winner : r_last;

  always_comb begin
    w_op  = '0;
    w_sel = '0;
    w_en  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_src == IW'(i)) begin
        w_op  = req_op[4*i +: 4];
        w_sel = req_sel[4*i +: 4];
        w_en  = req_en[i];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_DRIVE;
      S_DRIVE: if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = w_xfer ? S_DRIVE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(NREQ-1);
      r_gnt    <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sel    <= '0;
      r_en     <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);
      if (w_xfer) begin
        r_op     <= w_op;
        r_sel    <= w_sel;
        r_en     <= w_en;
        r_active <= 1'b1;
        r_cnt    <= 4'(HOLD_CYC-1);
        r_gnt    <= w_src;
        r_last   <= w_src;
      end else if (r_state == S_DRIVE) begin
        if (r_cnt == 4'd0) begin
          r_op     <= '0;
          r_sel    <= '0;
          r_en     <= 1'b0;
          r_active <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

`ifdef ALCOM_SCHED_BURST_EN
  // Burst count restarts at 1 on every round-robin grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_burst <= '0;
    else if (w_xfer) r_burst <= (r_state == S_IDLE) ? 4'd1 : r_burst + 4'd1;
  end
`endif

  assign dec_op     = r_op;
  assign dec_sel    = r_sel;
  assign dec_en     = r_en;
  assign dec_active = r_active;
  assign gnt_id     = r_gnt;
  assign done       = r_done;
  assign busy       = r_busy;
endmodule

// File: tb/tb_alcom_sched.sv
// Self-checking bench for alcom_sched: vector table, hand sequences, random run vs reference model.
module tb_alcom_sched;
  localparam int N = 4;
  localparam int H = 2;
  localparam int BMAX = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [4*N-1:0] req_op = '0, req_sel = '0;
  logic [N-1:0]   req_en = '0;
  logic [N-1:0]   req_ready;
  logic [3:0]     dec_op, dec_sel;
  logic           dec_en, dec_active, done, busy;
  logic [1:0]     gnt_id;

  int n_chk = 0;
  int n_fail = 0;

  alcom_sched #(.NREQ(N), .HOLD_CYC(H), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_sel(req_sel), .req_en(req_en), .req_ready(req_ready),
    .dec_op(dec_op), .dec_sel(dec_sel), .dec_en(dec_en),
    .dec_active(dec_active), .gnt_id(gnt_id), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] op;
    logic [15:0] sel;
    logic [3:0]  en;
    logic [3:0]  rdy;
    int          gnt;
    logic [3:0]  eop;
    logic [3:0]  esel;
    logic        een;
  } vec_t;
  vec_t tbl[6];

  int exp_g[6];
  int exp_sp[5];

  task automatic run_order(input logic [N-1:0] mask, input string tag);
    int got_g[$];
    int got_t[$];
    do_reset();
    @(negedge clk);
    req_valid = mask;
    req_op = 16'h4321;
    req_sel = 16'h8765;
    req_en = 4'b1111;
    for (int cyc = 0; cyc < 80 && got_g.size() < 6; cyc++) begin
      @(negedge clk);
      #1;
      if (done) begin
        got_g.push_back(int'(gnt_id));
        got_t.push_back(cyc);
      end
    end
    req_valid = '0;
    chk({tag, "_count"}, got_g.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_g.size()) chk({tag, "_gnt"}, got_g[i], exp_g[i]);
    for (int i = 0; i < 5; i++)
      if (i + 1 < got_t.size()) chk({tag, "_spacing"}, got_t[i+1] - got_t[i], exp_sp[i]);
    repeat (6) @(negedge clk);
  endtask

  // Reference model: cycles since grant (0 = idle, 1..H = hold, H+1 = completion).
  int m_t, m_last, m_gnt, m_burst;
  logic [3:0] m_op, m_sel;
  logic m_en;
  logic h_valid[N];
  logic [3:0] h_op[N], h_sel[N];
  logic h_en[N];

  initial begin
    int n_done, n_bad;
    logic [N-1:0] v, erdy;
    int w;

    tbl[0] = '{4'b0100, 16'h0900, 16'h0600, 4'b0100, 4'b0100, 2, 4'h9, 4'h6, 1'b1};
    tbl[1] = '{4'b1011, 16'hA3C5, 16'h1234, 4'b1000, 4'b1000, 3, 4'hA, 4'h1, 1'b1};
    tbl[2] = '{4'b1011, 16'hA3C5, 16'h1234, 4'b0001, 4'b0001, 0, 4'h5, 4'h4, 1'b1};
    tbl[3] = '{4'b1010, 16'hA3C5, 16'h1234, 4'b0001, 4'b0010, 1, 4'hC, 4'h3, 1'b0};
    tbl[4] = '{4'b0001, 16'h000F, 16'h000F, 4'b0000, 4'b0001, 0, 4'hF, 4'hF, 1'b0};
    tbl[5] = '{4'b1111, 16'h8765, 16'hFEDC, 4'b1111, 4'b0010, 1, 4'h6, 4'hD, 1'b1};

    do_reset();
    #1;
    chk("rst_dec_op", dec_op, 0);
    chk("rst_dec_sel", dec_sel, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_active", dec_active, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_ready_none", req_ready, 0);
    req_valid = 4'b1111;
    #1;
    chk("rst_ready_prio0", req_ready, 4'b0001);
    req_valid = '0;

    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      req_valid = tbl[r].valid;
      req_op = tbl[r].op;
      req_sel = tbl[r].sel;
      req_en = tbl[r].en;
      #1;
      chk("tbl_idle_busy", busy, 0);
      chk("tbl_ready", req_ready, tbl[r].rdy);
      @(negedge clk);
      req_valid = '0;
      for (int h = 0; h < H; h++) begin
        if (h > 0) @(negedge clk);
        #1;
        chk("tbl_active", dec_active, 1);
        chk("tbl_op", dec_op, tbl[r].eop);
        chk("tbl_sel", dec_sel, tbl[r].esel);
        chk("tbl_en", dec_en, tbl[r].een);
        chk("tbl_gnt", gnt_id, tbl[r].gnt);
        chk("tbl_nodone", done, 0);
        chk("tbl_ready_drive", req_ready, 0);
      end
      @(negedge clk);
      #1;
      chk("tbl_done", done, 1);
      chk("tbl_done_active", dec_active, 0);
      chk("tbl_done_op", dec_op, 0);
      chk("tbl_done_busy", busy, 1);
    end

`ifdef ALCOM_SCHED_BURST_EN
    exp_g = '{0, 0, 1, 1, 2, 2};
    exp_sp = '{3, 4, 3, 4, 3};
`else
    exp_g = '{0, 1, 2, 3, 0, 1};
    exp_sp = '{4, 4, 4, 4, 4};
`endif
    run_order(4'b1111, "all_valid");

`ifdef ALCOM_SCHED_BURST_EN
    exp_g = '{1, 1, 3, 3, 1, 1};
    exp_sp = '{3, 4, 3, 4, 3};
    run_order(4'b1010, "burst13");
`endif

    // Reset asserted in the second hold cycle.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010;
    req_op = 16'h00B0;
    req_sel = 16'h0070;
    req_en = 4'b0010;
    #1;
    chk("abort_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("abort_active1", dec_active, 1);
    @(negedge clk);
    #1;
    chk("abort_active2", dec_active, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_clr_active", dec_active, 0);
    chk("abort_clr_op", dec_op, 0);
    chk("abort_clr_sel", dec_sel, 0);
    chk("abort_clr_en", dec_en, 0);
    chk("abort_clr_busy", busy, 0);
    chk("abort_clr_gnt", gnt_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    req_valid = 4'b1111;
    #1;
    chk("abort_ready_after", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("abort_gnt_after", gnt_id, 0);
    repeat (5) @(negedge clk);

    // Single-cycle pulse while another transaction is being held.
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_op = 16'h0A03;
    req_sel = 16'h0504;
    req_en = 4'b0101;
    #1;
    chk("pulse_ready0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("pulse_ready_drive", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    n_done = 0;
    n_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (done) n_done++;
      if (dec_active && gnt_id == 2'd2) n_bad++;
    end
    chk("pulse_done_count", n_done, 1);
    chk("pulse_never_granted", n_bad, 0);
    chk("pulse_idle_busy", busy, 0);

    // Random run against the reference model.
    do_reset();
    m_t = 0; m_last = N - 1; m_gnt = 0; m_burst = 0;
    m_op = '0; m_sel = '0; m_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      h_valid[i] = 1'b0; h_op[i] = '0; h_sel[i] = '0; h_en[i] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!h_valid[i] && $urandom_range(0, 3) == 0) begin
          h_valid[i] = 1'b1;
          h_op[i] = 4'($urandom_range(0, 15));
          h_sel[i] = 4'($urandom_range(0, 15));
          h_en[i] = 1'($urandom_range(0, 1));
        end
        req_valid[i] = h_valid[i];
        req_op[4*i +: 4] = h_op[i];
        req_sel[4*i +: 4] = h_sel[i];
        req_en[i] = h_en[i];
      end
      v = req_valid;
      erdy = '0;
      w = -1;
      if (m_t == 0) begin
        w = rr_pick(v, m_last);
        if (w >= 0) erdy[w] = 1'b1;
      end
`ifdef ALCOM_SCHED_BURST_EN
      if (m_t == H + 1 && v[m_gnt] && m_burst < BMAX) begin
        w = m_gnt;
        erdy[w] = 1'b1;
      end
`endif
      #1;
      chk("rnd_ready", req_ready, erdy);
      chk("rnd_done", done, (m_t == H + 1) ? 1 : 0);
      chk("rnd_busy", busy, (m_t != 0) ? 1 : 0);
      chk("rnd_active", dec_active, (m_t >= 1 && m_t <= H) ? 1 : 0);
      chk("rnd_op", dec_op, (m_t >= 1 && m_t <= H) ? m_op : 0);
      chk("rnd_sel", dec_sel, (m_t >= 1 && m_t <= H) ? m_sel : 0);
      chk("rnd_en", dec_en, (m_t >= 1 && m_t <= H) ? m_en : 0);
      chk("rnd_gnt", gnt_id, m_gnt);
      if (erdy != '0) begin
        m_burst = (m_t == 0) ? 1 : m_burst + 1;
        m_t = 1;
        m_gnt = w;
        m_last = w;
        m_op = h_op[w];
        m_sel = h_sel[w];
        m_en = h_en[w];
        h_valid[w] = 1'b0;
      end else if (m_t == H + 1) begin
        m_t = 0;
      end else if (m_t != 0) begin
        m_t++;
      end
    end
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
